// File: rtl/sound_mailbox.sv
// Command/reply mailbox between the main CPU and the 6502 sound CPU.
// Main CPU queues command bytes in a small FIFO; each pending command is
// announced with an NMI to the sound CPU. After every pop the NMI is held low
// for NMI_GAP cycles so the 6502 always sees a fresh rising edge.
// The sound CPU answers through a single-byte reply latch that raises main_irq.
//
// NMI FSM states:
//   state  | meaning
//   IDLE   | no command queued, sndnmi low
//   ASSERT | command waiting, sndnmi high until the sound CPU pops it
//   GAP    | sndnmi forced low for NMI_GAP cycles after a pop
module sound_mailbox #(
    parameter int CMD_DEPTH = 4,
    parameter int NMI_GAP   = 2
) (
    input  logic       clock_15,
    input  logic       rst_l,
    input  logic       main_wr_cmd,
    input  logic [7:0] main_cmd_data,
    input  logic       main_rd_reply,
    input  logic       main_clr_err,
    output logic [7:0] main_reply_data,
    output logic       reply_ready,
    output logic       main_irq,
    output logic       cmd_full,
    output logic       cmd_overflow,
    output logic       reply_lost,
    input  logic       snd_rd_cmd,
    output logic [7:0] snd_cmd_data,
    output logic       cmd_pending,
    output logic       sndnmi,
    input  logic       snd_wr_reply,
    input  logic [7:0] snd_reply_data
);

    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int GW = $clog2(NMI_GAP + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } nmi_state_t;

    logic [7:0]    mem [CMD_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [GW-1:0] gap_cnt;
    nmi_state_t    state;

    logic is_full;
    logic is_empty;
    logic pop_ok;
    logic push_ok;
    logic push_drop;

    assign is_full  = (count == CW'(CMD_DEPTH));
    assign is_empty = (count == '0);

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign pop_ok    = snd_rd_cmd && !is_empty;
    assign push_ok   = main_wr_cmd && (!is_full || pop_ok);
    assign push_drop = main_wr_cmd && is_full && !pop_ok;

    // Occupancy after this edge; also steers the NMI FSM.
    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    assign cmd_full     = is_full;
    assign cmd_pending  = !is_empty;
    assign snd_cmd_data = is_empty ? 8'h00 : mem[rd_ptr];
    assign main_irq     = reply_ready;

    // Command FIFO storage, pointers and occupancy.
    always_ff @(posedge clock_15) begin
        if (!rst_l) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= main_cmd_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
        end
    end

    // NMI sequencing with a minimum low gap after each pop.
    always_ff @(posedge clock_15) begin
        if (!rst_l) begin
            state   <= IDLE;
            gap_cnt <= '0;
            sndnmi  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count_next != '0) begin
                        state  <= ASSERT;
                        sndnmi <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (snd_rd_cmd) begin
                        state   <= GAP;
                        gap_cnt <= GW'(NMI_GAP - 1);
                        sndnmi  <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else if (count_next != '0) begin
                        state  <= ASSERT;
                        sndnmi <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    sndnmi <= 1'b0;
                end
            endcase
        end
    end

    // Reply latch; a same-cycle sound write beats the main-side read.
    always_ff @(posedge clock_15) begin
        if (!rst_l) begin
            reply_ready     <= 1'b0;
            main_reply_data <= 8'h00;
        end else if (snd_wr_reply) begin
            reply_ready     <= 1'b1;
            main_reply_data <= snd_reply_data;
        end else if (main_rd_reply) begin
            reply_ready <= 1'b0;
        end
    end

    // Sticky error flags; a new event outranks a clear in the same cycle.
    always_ff @(posedge clock_15) begin
        if (!rst_l) begin
            cmd_overflow <= 1'b0;
            reply_lost   <= 1'b0;
        end else begin
            if (push_drop)         cmd_overflow <= 1'b1;
            else if (main_clr_err) cmd_overflow <= 1'b0;
            if (snd_wr_reply && reply_ready && !main_rd_reply) reply_lost <= 1'b1;
            else if (main_clr_err)                             reply_lost <= 1'b0;
        end
    end

endmodule
